sitcp_tx_framer: RTL

- Downstream packetizer that feeds the SiTCP TCP transmit byte interface (TCP_TX_WR / TCP_TX_DATA / TCP_TX_FULL) from a 32-bit word stream.
- Typical source is a readout FIFO.
- Wraps every FRAME_WORDS words in a frame: 6-byte header, payload, 1-byte XOR trailer.
- Honours TCP_TX_FULL back-pressure and aborts cleanly when the TCP connection drops.

---
 rtl/sitcp_tx_framer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sitcp_tx_framer.sv
// sitcp_tx_framer: packs a 32-bit word stream into framed bytes for the SiTCP
// TCP transmit interface. Frame = MAGIC, SEQ, LEN header (6 bytes), payload
// words MSB first, then one XOR byte over the payload.
module sitcp_tx_framer #(
  parameter int unsigned FRAME_WORDS = 256,
  parameter logic [15:0] MAGIC       = 16'hEB90
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        TCP_OPEN,
  input  logic        TCP_TX_FULL,
  output logic        TCP_TX_WR,
  output logic [7:0]  TCP_TX_DATA,
  input  logic [31:0] DIN,
  input  logic        DIN_VALID,
  output logic        DIN_READY,
  output logic [31:0] FRAME_CNT,
  output logic        BUSY
);

  localparam logic [15:0] LEN    = 16'(FRAME_WORDS << 2);
  localparam logic [13:0] LAST_W = 14'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;

  state_t      state, state_n;
  logic [2:0]  idx;      // header byte index
  logic [13:0] wcnt;     // payload words fully sent in this frame
  logic [31:0] shreg;    // current word, next byte in [31:24]
  logic [2:0]  bcnt;     // bytes still pending in shreg, 0 = empty
  logic [7:0]  xor_r;
  logic [15:0] seq_r;
  logic        emit;
  logic [7:0]  byte_n;
  logic [7:0]  hdr_byte;
  logic        load;

  // Ready only when the shift register is drained, so a word is never overwritten.
  assign DIN_READY = (state == PAY) && (bcnt == 3'd0) && TCP_OPEN;
  assign load      = DIN_READY && DIN_VALID;
  assign BUSY      = (state != IDLE);

  // Header byte selected by idx.
  always_comb begin
    hdr_byte = 8'h00;
    case (idx)
      3'd0:    hdr_byte = MAGIC[15:8];
      3'd1:    hdr_byte = MAGIC[7:0];
      3'd2:    hdr_byte = seq_r[15:8];
      3'd3:    hdr_byte = seq_r[7:0];
      3'd4:    hdr_byte = LEN[15:8];
      3'd5:    hdr_byte = LEN[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Next state and byte-emit decision; a byte goes out only while FULL is low.
  always_comb begin
    state_n = state;
    emit    = 1'b0;
    byte_n  = 8'h00;
    case (state)
      IDLE: if (DIN_VALID) state_n = HDR;
      HDR: begin
        emit   = !TCP_TX_FULL;
        byte_n = hdr_byte;
        if (emit && idx == 3'd5) state_n = PAY;
      end
      PAY: begin
        emit   = !TCP_TX_FULL && (bcnt != 3'd0);
        byte_n = shreg[31:24];
        if (emit && bcnt == 3'd1 && wcnt == LAST_W) state_n = TRL;
      end
      TRL: begin
        emit   = !TCP_TX_FULL;
        byte_n = xor_r;
        if (emit) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Losing the connection overrides everything and drops the partial frame.
    if (!TCP_OPEN) begin
      state_n = IDLE;
      emit    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_n;
  end

  // Datapath: output byte register, counters, shift register, checksum, seq.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      TCP_TX_WR   <= 1'b0;
      TCP_TX_DATA <= 8'h00;
      FRAME_CNT   <= 32'd0;
      idx         <= 3'd0;
      wcnt        <= 14'd0;
      shreg       <= 32'd0;
      bcnt        <= 3'd0;
      xor_r       <= 8'h00;
      seq_r       <= 16'd0;
    end else if (!TCP_OPEN) begin
      TCP_TX_WR <= 1'b0;
      FRAME_CNT <= 32'd0;
      idx       <= 3'd0;
      wcnt      <= 14'd0;
      shreg     <= 32'd0;
      bcnt      <= 3'd0;
      xor_r     <= 8'h00;
      seq_r     <= 16'd0;
    end else begin
      TCP_TX_WR <= emit;
      if (emit) TCP_TX_DATA <= byte_n;
      case (state)
        IDLE: idx <= 3'd0;
        HDR: if (emit) begin
          idx <= idx + 3'd1;
          if (idx == 3'd5) wcnt <= 14'd0;
        end
        PAY: begin
          if (load) begin
            shreg <= DIN;
            bcnt  <= 3'd4;
          end else if (emit) begin
            shreg <= {shreg[23:0], 8'h00};
            bcnt  <= bcnt - 3'd1;
            xor_r <= xor_r ^ byte_n;
            if (bcnt == 3'd1) wcnt <= wcnt + 14'd1;
          end
        end
        TRL: if (emit) begin
          seq_r     <= seq_r + 16'd1;
          FRAME_CNT <= FRAME_CNT + 32'd1;
          xor_r     <= 8'h00;
        end
        default: ;
      endcase
    end
  end

endmodule
